// File: rtl/redpitaya_rst_pkg.sv
// Shared state codes and sizing helpers for the PLL reset/lock sequencer.
// Pure definitions: no logic, no latency.
package redpitaya_rst_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Wide enough to reach the largest terminal count minus one without wrapping.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/redpitaya_sync_bit.sv
// Multi-stage single-bit synchronizer for asynchronous status inputs.
// Latency STAGES clk cycles; no flow control.
module redpitaya_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/redpitaya_pll_rst_seq.sv
// Sequences PLL reset, qualifies lock, then releases the DAC-domain reset; counts lock losses/timeouts.
// Lock loss in RUN reaches dac_rstn_o after SYNC_STAGES+1 cycles; no flow control.
module redpitaya_pll_rst_seq
    import redpitaya_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 8
) (
    input  logic               adc_clk_i,
    input  logic               adc_rstn_i,
    input  logic               pll_locked_i,
    input  logic               soft_rst_i,
    input  logic               clr_cnt_i,
    output logic               pll_rst_o,
    output logic               dac_rstn_o,
    output logic               ready_o,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   lock_loss_cnt_o,
    output logic [CNT_W-1:0]   timeout_cnt_o
);

    localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);

    state_t        state;
    state_t        nxt;
    logic [TW-1:0] timer;
    logic          lk;
    logic          restart;
    logic          inc_to;
    logic          inc_ll;

    redpitaya_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (adc_clk_i),
        .rst_n(adc_rstn_i),
        .d    (pll_locked_i),
        .q    (lk)
    );

    always_comb begin
        nxt    = state;
        inc_to = 1'b0;
        inc_ll = 1'b0;
        if (soft_rst_i) begin
            nxt = PLL_RST;
        end else begin
            case (state)
                PLL_RST: begin
                    if (timer == RST_LAST) nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        nxt = STABLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        nxt    = PLL_RST;
                        inc_to = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        nxt = WAIT_LOCK;
                    end else if (timer == STABLE_LAST) begin
                        nxt = RUN;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        nxt    = PLL_RST;
                        inc_ll = 1'b1;
                    end
                end
                default: nxt = PLL_RST;
            endcase
        end
        // A soft reset while already in PLL_RST still restarts the pulse.
        restart = soft_rst_i || (nxt != state);
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state           <= PLL_RST;
            timer           <= '0;
            pll_rst_o       <= 1'b1;
            dac_rstn_o      <= 1'b0;
            ready_o         <= 1'b0;
            lock_loss_cnt_o <= '0;
            timeout_cnt_o   <= '0;
        end else begin
            state <= nxt;
            if (restart) begin
                timer <= '0;
            end else if (state != RUN) begin
                timer <= timer + TW'(1);
            end
            pll_rst_o  <= (nxt == PLL_RST);
            dac_rstn_o <= (nxt == RUN);
            ready_o    <= (nxt == RUN);
            if (clr_cnt_i) begin
                lock_loss_cnt_o <= '0;
                timeout_cnt_o   <= '0;
            end else begin
                if (inc_ll && (lock_loss_cnt_o != '1)) lock_loss_cnt_o <= lock_loss_cnt_o + CNT_W'(1);
                if (inc_to && (timeout_cnt_o != '1))   timeout_cnt_o   <= timeout_cnt_o + CNT_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_redpitaya_pll_rst_seq.sv
// Scoreboard bench for the PLL reset/lock sequencer with small timing parameters.
module tb_redpitaya_pll_rst_seq;

    localparam int SIG_PLLRST = 0;
    localparam int SIG_READY  = 1;
    localparam int SIG_DACRST = 2;
    localparam int SIG_STATE  = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pll_locked;
    logic       soft_rst;
    logic       clr_cnt;
    logic       pll_rst;
    logic       dac_rstn;
    logic       ready;
    logic [1:0] state;
    logic [1:0] ll_cnt;
    logic [1:0] to_cnt;

    typedef struct {
        string  name;
        integer val;
    } exp_t;

    exp_t   exp_q[$];
    integer obs_q[$];
    int     checks   = 0;
    int     failures = 0;

    redpitaya_pll_rst_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2),
        .CNT_W         (2)
    ) dut (
        .adc_clk_i      (clk),
        .adc_rstn_i     (rstn),
        .pll_locked_i   (pll_locked),
        .soft_rst_i     (soft_rst),
        .clr_cnt_i      (clr_cnt),
        .pll_rst_o      (pll_rst),
        .dac_rstn_o     (dac_rstn),
        .ready_o        (ready),
        .state_o        (state),
        .lock_loss_cnt_o(ll_cnt),
        .timeout_cnt_o  (to_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic integer sig(input int which);
        case (which)
            SIG_PLLRST: return {31'd0, pll_rst};
            SIG_READY:  return {31'd0, ready};
            SIG_DACRST: return {31'd0, dac_rstn};
            default:    return {30'd0, state};
        endcase
    endfunction

    // Cycles until the chosen output equals val; -1 if the budget runs out.
    task automatic count_until(input int which, input integer val, input int max, output int n);
        n = 0;
        while (sig(which) !== val && n < max) begin
            cyc();
            n++;
        end
        if (sig(which) !== val) n = -1;
    endtask

    task automatic expect_push(input string name, input integer val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t   e;
        integer o;
        rstn = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0; clr_cnt = 1'b0;
        expect_push("rst_pll_rst", 1);
        expect_push("rst_dac_rstn", 0);
        expect_push("rst_ready", 0);
        expect_push("rst_state", 0);
        expect_push("rst_ll_cnt", 0);
        expect_push("rst_to_cnt", 0);
        repeat (3) cyc();
        obs_q.push_back({31'd0, pll_rst});
        obs_q.push_back({31'd0, dac_rstn});
        obs_q.push_back({31'd0, ready});
        obs_q.push_back({30'd0, state});
        obs_q.push_back({30'd0, ll_cnt});
        obs_q.push_back({30'd0, to_cnt});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -999;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_lock_sequence();
        exp_t   e;
        integer o;
        int     n;
        expect_push("seq_pll_rst_len", 4);
        rstn = 1'b1;
        count_until(SIG_PLLRST, 0, 50, n);
        obs_q.push_back(n);
        repeat (10) cyc();
        expect_push("seq_to_stable", 3);
        pll_locked = 1'b1;
        count_until(SIG_STATE, 2, 50, n);
        obs_q.push_back(n);
        expect_push("seq_stable_to_ready", 8);
        count_until(SIG_READY, 1, 50, n);
        obs_q.push_back(n);
        expect_push("seq_dac_rstn", 1);
        expect_push("seq_state_run", 3);
        obs_q.push_back({31'd0, dac_rstn});
        obs_q.push_back({30'd0, state});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -999;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t   e;
        integer o;
        int     n;
        expect_push("to_soft_state", 0);
        soft_rst = 1'b1; pll_locked = 1'b0;
        cyc();
        soft_rst = 1'b0;
        obs_q.push_back({30'd0, state});
        for (int i = 1; i <= 4; i++) begin
            expect_push($sformatf("to_high_%0d", i), 4);
            expect_push($sformatf("to_low_%0d", i), 32);
            expect_push($sformatf("to_cnt_%0d", i), (i > 3) ? 3 : i);
            count_until(SIG_PLLRST, 0, 100, n);
            obs_q.push_back(n);
            count_until(SIG_PLLRST, 1, 100, n);
            obs_q.push_back(n);
            obs_q.push_back({30'd0, to_cnt});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -999;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_lock_loss();
        exp_t   e;
        integer o;
        int     n;
        pll_locked = 1'b1;
        count_until(SIG_STATE, 3, 200, n);
        expect_push("ll_run_reached", 1);
        obs_q.push_back((n >= 0) ? 1 : 0);
        expect_push("ll_dac_rstn_latency", 3);
        pll_locked = 1'b0;
        cyc();
        pll_locked = 1'b1;
        count_until(SIG_DACRST, 0, 20, n);
        obs_q.push_back((n >= 0) ? n + 1 : -1);
        expect_push("ll_cnt", 1);
        expect_push("ll_state", 0);
        obs_q.push_back({30'd0, ll_cnt});
        obs_q.push_back({30'd0, state});
        expect_push("ll_resequence_to_ready", 13);
        count_until(SIG_READY, 1, 100, n);
        obs_q.push_back(n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -999;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_stable_glitch();
        exp_t   e;
        integer o;
        int     n;
        expect_push("sg_soft_to_stable", 5);
        soft_rst = 1'b1;
        cyc();
        soft_rst = 1'b0;
        count_until(SIG_STATE, 2, 50, n);
        obs_q.push_back(n);
        repeat (5) cyc();
        expect_push("sg_to_wait_lock", 3);
        pll_locked = 1'b0;
        cyc();
        pll_locked = 1'b1;
        count_until(SIG_STATE, 1, 20, n);
        obs_q.push_back((n >= 0) ? n + 1 : -1);
        expect_push("sg_ll_cnt", 1);
        expect_push("sg_to_cnt", 3);
        obs_q.push_back({30'd0, ll_cnt});
        obs_q.push_back({30'd0, to_cnt});
        expect_push("sg_back_to_stable", 1);
        count_until(SIG_STATE, 2, 20, n);
        obs_q.push_back(n);
        expect_push("sg_stable_to_ready", 8);
        count_until(SIG_READY, 1, 50, n);
        obs_q.push_back(n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -999;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_soft_and_clear();
        exp_t   e;
        integer o;
        int     n;
        pll_locked = 1'b0;
        repeat (2) cyc();
        expect_push("sc_soft_state", 0);
        expect_push("sc_ll_unchanged", 1);
        soft_rst = 1'b1;
        cyc();
        soft_rst = 1'b0;
        obs_q.push_back({30'd0, state});
        obs_q.push_back({30'd0, ll_cnt});
        count_until(SIG_PLLRST, 0, 20, n);
        repeat (31) cyc();
        expect_push("sc_pre_clr_to_cnt", 3);
        expect_push("sc_pre_clr_state", 1);
        obs_q.push_back({30'd0, to_cnt});
        obs_q.push_back({30'd0, state});
        expect_push("sc_clr_to_cnt", 0);
        expect_push("sc_clr_ll_cnt", 0);
        expect_push("sc_timeout_state", 0);
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        obs_q.push_back({30'd0, to_cnt});
        obs_q.push_back({30'd0, ll_cnt});
        obs_q.push_back({30'd0, state});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -999;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t   e;
        integer o;
        int     n;
        count_until(SIG_PLLRST, 0, 20, n);
        count_until(SIG_PLLRST, 1, 100, n);
        count_until(SIG_PLLRST, 0, 20, n);
        repeat (3) cyc();
        expect_push("ar_pre_to_cnt", 1);
        expect_push("ar_pre_state", 1);
        obs_q.push_back({30'd0, to_cnt});
        obs_q.push_back({30'd0, state});
        expect_push("ar_pll_rst", 1);
        expect_push("ar_dac_rstn", 0);
        expect_push("ar_ready", 0);
        expect_push("ar_state", 0);
        expect_push("ar_to_cnt", 0);
        expect_push("ar_ll_cnt", 0);
        #2;
        rstn = 1'b0;
        #1;
        obs_q.push_back({31'd0, pll_rst});
        obs_q.push_back({31'd0, dac_rstn});
        obs_q.push_back({31'd0, ready});
        obs_q.push_back({30'd0, state});
        obs_q.push_back({30'd0, to_cnt});
        obs_q.push_back({30'd0, ll_cnt});
        repeat (2) cyc();
        expect_push("ar_restart_pulse", 4);
        rstn = 1'b1;
        count_until(SIG_PLLRST, 0, 20, n);
        obs_q.push_back(n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -999;
            checks++;
            if (o !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d required %0d", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_timeout();
        test_lock_loss();
        test_stable_glitch();
        test_soft_and_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
